// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - IF/DM arbiter for a shared single-ported 16-bit memory
// Optional ARB_FLUSH_EN adds if_flush to block IF grants and squash in-flight fetches.
module imem_dmem_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef ARB_FLUSH_EN
    input  logic        if_flush,
`endif
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [15:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [15:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_dm
);
    localparam int LW = $clog2(MEM_LATENCY + 1) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic            owner_dm;
    logic            owner_we;
    logic            dead;
    logic [LW-1:0]   lat_cnt;
    logic [SW-1:0]   starve_cnt;
    logic            if_block;
    logic            starved;
    logic            grant_if;
    logic            grant_dm;
    logic            sample;

`ifdef ARB_FLUSH_EN
    assign if_block = if_flush;
`else
    assign if_block = 1'b0;
`endif

    assign starved  = (starve_cnt == SW'(STARVE_LIMIT));
    assign grant_if = if_req & ~if_block & (~dm_req | starved);
    assign grant_dm = dm_req & ~grant_if;
    assign sample   = (state_q == BUSY) && (lat_cnt == LW'(MEM_LATENCY));

    assign stall_if = if_req & ~if_valid;
    assign stall_dm = dm_req & ~dm_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_if || grant_dm) state_d = BUSY;
            BUSY:    if (sample) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            owner_dm   <= 1'b0;
            owner_we   <= 1'b0;
            dead       <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            if_gnt   <= 1'b0;
            dm_gnt   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if (!if_req) starve_cnt <= '0;
            if (state_q == IDLE) begin
                if (grant_if) begin
                    owner_dm   <= 1'b0;
                    owner_we   <= 1'b0;
                    if_gnt     <= 1'b1;
                    mem_en     <= 1'b1;
                    mem_addr   <= if_addr;
                    lat_cnt    <= '0;
                    starve_cnt <= '0;
                end else if (grant_dm) begin
                    owner_dm  <= 1'b1;
                    owner_we  <= dm_we;
                    dm_gnt    <= 1'b1;
                    mem_en    <= 1'b1;
                    mem_we    <= dm_we;
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                    lat_cnt   <= '0;
                    // saturates at the limit; only reachable there when a flush blocked IF
                    if (if_req && !starved) starve_cnt <= starve_cnt + SW'(1);
                end
            end else begin
                lat_cnt <= lat_cnt + LW'(1);
                if (!owner_dm && if_block) dead <= 1'b1;
                if (sample) begin
                    dead <= 1'b0;
                    if (owner_dm) begin
                        dm_valid <= 1'b1;
                        if (!owner_we) dm_rdata <= mem_rdata;
                    end else if (!(dead || if_block)) begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - scoreboard bench for imem_dmem_arbiter
module tb_imem_dmem_arbiter;
    localparam int LAT = 3;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
`ifdef ARB_FLUSH_EN
    logic        if_flush;
`endif
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [15:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_valid;
    logic [15:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall_if;
    logic        stall_dm;

    logic [15:0] rd_addr = '0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          tmo_n = 0;
    bit          done = 0;
    bit          fin = 0;

    exp_t gq[$];   // grants: data[0] = 1 for DM
    exp_t iq[$];   // if_valid responses
    exp_t dq[$];   // dm_valid responses
    exp_t wq[$];   // writes: cyc holds address
    exp_t pq[$];   // if_rdata probes at a given cycle

    imem_dmem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ARB_FLUSH_EN
        .if_flush(if_flush),
`endif
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // read data is a fixed function of the captured address
    always @(posedge clk) if (mem_en) rd_addr <= mem_addr;
    assign mem_rdata = (rd_addr == 16'h0010) ? 16'hABCD : (rd_addr ^ 16'hC3C3);

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("reset_strobes", {if_gnt, dm_gnt, if_valid, dm_valid, mem_en, mem_we}, 0);
            chk("reset_data", {if_rdata, dm_rdata}, 0);
            chk("reset_mem_addr", mem_addr, 0);
        end else begin
            if (if_gnt || dm_gnt) begin
                chk("mem_en_at_gnt", mem_en, 1);
                if (gq.size() == 0) chk("stray_gnt", {if_gnt, dm_gnt}, 0);
                else begin
                    e = gq.pop_front();
                    chk("gnt_owner", {if_gnt, dm_gnt}, e.data[0] ? 2'b01 : 2'b10);
                    chk("gnt_cycle", cyc, e.cyc);
                    if (if_gnt) chk("stall_if_at_gnt", stall_if, 1);
                    if (dm_gnt) chk("stall_dm_at_gnt", stall_dm, 1);
                end
            end
            if (if_valid) begin
                if (iq.size() == 0) chk("stray_if_valid", if_valid, 0);
                else begin
                    e = iq.pop_front();
                    chk("if_rdata", if_rdata, e.data);
                    chk("if_valid_cycle", cyc, e.cyc);
                    chk("stall_if_release", stall_if, 0);
                end
            end
            if (dm_valid) begin
                if (dq.size() == 0) chk("stray_dm_valid", dm_valid, 0);
                else begin
                    e = dq.pop_front();
                    chk("dm_rdata", dm_rdata, e.data);
                    chk("dm_valid_cycle", cyc, e.cyc);
                end
            end
            if (mem_we) begin
                chk("we_needs_en", mem_en, 1);
                if (wq.size() == 0) chk("stray_write", mem_we, 0);
                else begin
                    e = wq.pop_front();
                    chk("write_addr", mem_addr, e.cyc);
                    chk("write_data", mem_wdata, e.data);
                end
            end
            if (pq.size() != 0 && pq[0].cyc == cyc) begin
                e = pq.pop_front();
                chk("if_rdata_hold", if_rdata, e.data);
            end
        end
        if (done && !fin) begin
            chk("timeouts", tmo_n, 0);
            chk("leftover_expects", gq.size() + iq.size() + dq.size() + wq.size() + pq.size(), 0);
            fin = 1;
        end
    end

    task automatic if_fetch(input logic [15:0] a);
        bit got = 0;
        if_addr = a;
        if_req  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_gnt) begin got = 1; break; end
        end
        if (!got) tmo_n++;
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic dm_access(input logic we, input logic [15:0] a, input logic [15:0] d);
        bit got = 0;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = d;
        dm_req   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dm_gnt) begin got = 1; break; end
        end
        if (!got) tmo_n++;
        @(posedge clk); #1;
        dm_req = 1'b0;
    endtask

    task automatic drain();
        bit empty = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (gq.size() + iq.size() + dq.size() + wq.size() + pq.size() == 0) begin
                empty = 1;
                break;
            end
        end
        if (!empty) tmo_n++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int x;
        int nd;
        int ni;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
`ifdef ARB_FLUSH_EN
        if_flush = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // asynchronous reset in the middle of an IF access: nothing may come back
        x = cyc;
        gq.push_back('{x + 1, 16'h0});
        if_fetch(16'h0050);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;

        // lone IF fetch with exact timing
        x = cyc;
        gq.push_back('{x + 1, 16'h0});
        iq.push_back('{x + LAT + 2, 16'hABCD});
        if_fetch(16'h0010);
        drain();

        // simultaneous requests: DM first, IF granted right after dm_valid
        x = cyc;
        gq.push_back('{x + 1, 16'h1});
        gq.push_back('{x + LAT + 3, 16'h0});
        dq.push_back('{x + LAT + 2, 16'hC1C3});
        iq.push_back('{x + 2 * LAT + 4, 16'hC3F3});
        fork
            if_fetch(16'h0030);
            dm_access(1'b0, 16'h0200, 16'h0000);
        join
        drain();

        // starvation: four DM grants, forced IF grant, then DM again
        x = cyc;
        for (int k = 0; k < 6; k++) begin
            gq.push_back('{x + 1 + k * (LAT + 2), (k == 4) ? 16'h0 : 16'h1});
            if (k == 4) iq.push_back('{x + 1 + k * (LAT + 2) + LAT + 1, 16'hC3E3});
            else        dq.push_back('{x + 1 + k * (LAT + 2) + LAT + 1, 16'hC7C3});
        end
        dm_we = 1'b0; dm_addr = 16'h0400; dm_req = 1'b1;
        if_addr = 16'h0020; if_req = 1'b1;
        nd = 0; ni = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dm_gnt) nd++;
            if (if_gnt) ni++;
            @(posedge clk); #1;
            if (ni > 0) if_req = 1'b0;
            if (nd >= 5) break;
        end
        if (nd < 5) tmo_n++;
        dm_req = 1'b0;
        if_req = 1'b0;
        drain();

        // DM write: strobe with we, dm_rdata keeps last read value
        x = cyc;
        gq.push_back('{x + 1, 16'h1});
        wq.push_back('{32'h0300, 16'h1234});
        dq.push_back('{x + LAT + 2, 16'hC7C3});
        dm_access(1'b1, 16'h0300, 16'h1234);
        drain();

`ifdef ARB_FLUSH_EN
        // flush during IF access: no valid, if_rdata keeps previous fetch
        x = cyc;
        gq.push_back('{x + 1, 16'h0});
        pq.push_back('{x + LAT + 4, 16'hC3E3});
        if_fetch(16'h0060);
        if_flush = 1'b1;
        @(posedge clk); #1;
        if_flush = 1'b0;
        drain();

        // flush in IDLE delays the grant by a cycle; access then completes normally
        x = cyc;
        if_flush = 1'b1;
        gq.push_back('{x + 2, 16'h0});
        iq.push_back('{x + LAT + 3, 16'hC3B3});
        fork
            if_fetch(16'h0070);
            begin
                @(posedge clk); #1;
                if_flush = 1'b0;
            end
        join
        drain();
`endif

        done = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (fin) break;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
